seq_gen: RTL and testbench

//  Upstream source for the 8-digit display stage: produces prog[2:0], modulo[1:0]
//  and data_2[15:0] (always 0..9999, four decimal digits). Two buttons cycle the

---
 rtl/seq_gen.sv | 163 ++++++++++++++++
 tb/tb_seq_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Numeric sequence source for the 8-digit display: two button-driven selectors
// (sequence and speed) and a prescaled step that walks data_2 through 0..9999 values.
module seq_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_prog,
  input  logic        btn_mod,
  input  logic        hold,
  output logic [2:0]  prog,
  output logic [1:0]  modulo,
  output logic [15:0] data_2
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] SEQ_UP   = 3'd0;
  localparam logic [2:0] SEQ_DOWN = 3'd1;
  localparam logic [2:0] SEQ_FIB  = 3'd2;
  localparam logic [2:0] SEQ_EVEN = 3'd3;
  localparam logic [2:0] SEQ_ODD  = 3'd4;
  localparam logic [2:0] SEQ_SQ   = 3'd5;
  localparam logic [2:0] SEQ_POW2 = 3'd6;
  localparam logic [2:0] SEQ_TRI  = 3'd7;

  logic [2:0]    prog_sync_r, mod_sync_r;
  logic [2:0]    prog_r;
  logic [1:0]    modulo_r;
  logic [15:0]   data_r;
  logic [PW-1:0] pre_r;
  logic [2:0]    cnt_r;
  logic [7:0]    n_r;
  logic [15:0]   a_r, b_r;

  logic          prog_pulse_s, mod_pulse_s, tick_s, step_s;
  logic [15:0]   step_data_s, step_a_s, step_b_s;
  logic [7:0]    step_n_s;
  logic [15:0]   nw_s;

  function automatic logic [15:0] start_data(input logic [2:0] p);
    logic [15:0] v;
    case (p)
      SEQ_DOWN: v = 16'd9999;
      SEQ_ODD:  v = 16'd1;
      SEQ_POW2: v = 16'd1;
      default:  v = 16'd0;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] step_last(input logic [1:0] m);
    logic [2:0] v;
    case (m)
      2'd0:    v = 3'd0;
      2'd1:    v = 3'd1;
      2'd2:    v = 3'd3;
      default: v = 3'd7;
    endcase
    return v;
  endfunction

  assign prog_pulse_s = prog_sync_r[1] & ~prog_sync_r[2];
  assign mod_pulse_s  = mod_sync_r[1] & ~mod_sync_r[2];
  assign tick_s       = ~hold & (pre_r == PRE_LAST);
  assign step_s       = tick_s & (cnt_r == step_last(modulo_r));

  // Button synchronisers: bit0 first stage, bit2 delayed copy for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prog_sync_r <= 3'd0;
      mod_sync_r  <= 3'd0;
    end else begin
      prog_sync_r <= {prog_sync_r[1:0], btn_prog};
      mod_sync_r  <= {mod_sync_r[1:0], btn_mod};
    end
  end

  // Next value of the selected sequence, applied only on a step edge
  always_comb begin
    step_data_s = data_r;
    step_a_s    = a_r;
    step_b_s    = b_r;
    step_n_s    = n_r;
    nw_s        = 16'd0;
    case (prog_r)
      SEQ_UP:   step_data_s = (data_r == 16'd9999) ? 16'd0 : data_r + 16'd1;
      SEQ_DOWN: step_data_s = (data_r == 16'd0) ? 16'd9999 : data_r - 16'd1;
      SEQ_FIB: begin
        if (b_r > 16'd9999) begin
          step_a_s = 16'd0;
          step_b_s = 16'd1;
        end else begin
          step_a_s = b_r;
          step_b_s = a_r + b_r;
        end
        step_data_s = step_a_s;
      end
      SEQ_EVEN: step_data_s = (data_r == 16'd9998) ? 16'd0 : data_r + 16'd2;
      SEQ_ODD:  step_data_s = (data_r == 16'd9999) ? 16'd1 : data_r + 16'd2;
      SEQ_SQ: begin
        step_n_s    = (n_r == 8'd99) ? 8'd0 : n_r + 8'd1;
        nw_s        = {8'd0, step_n_s};
        step_data_s = nw_s * nw_s;
      end
      SEQ_POW2: step_data_s = (data_r == 16'd8192) ? 16'd1 : {data_r[14:0], 1'b0};
      SEQ_TRI: begin
        step_n_s    = (n_r == 8'd140) ? 8'd0 : n_r + 8'd1;
        nw_s        = {8'd0, step_n_s};
        step_data_s = (nw_s * (nw_s + 16'd1)) >> 1;
      end
      default:  step_data_s = data_r;
    endcase
  end

  // Sequence state, prescaler and step counter; a prog change overrides a step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prog_r <= 3'd0;
      data_r <= 16'd0;
      pre_r  <= '0;
      cnt_r  <= 3'd0;
      n_r    <= 8'd0;
      a_r    <= 16'd0;
      b_r    <= 16'd1;
    end else begin
      if (prog_pulse_s) begin
        prog_r <= prog_r + 3'd1;
        data_r <= start_data(prog_r + 3'd1);
        pre_r  <= '0;
        cnt_r  <= 3'd0;
        n_r    <= 8'd0;
        a_r    <= 16'd0;
        b_r    <= 16'd1;
      end else begin
        if (!hold) pre_r <= tick_s ? '0 : pre_r + PW'(1);
        if (tick_s) cnt_r <= step_s ? 3'd0 : cnt_r + 3'd1;
        if (step_s) begin
          data_r <= step_data_s;
          n_r    <= step_n_s;
          a_r    <= step_a_s;
          b_r    <= step_b_s;
        end
      end
      if (mod_pulse_s) cnt_r <= 3'd0;
    end
  end

  // Speed selector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modulo_r <= 2'd0;
    end else if (mod_pulse_s) begin
      modulo_r <= modulo_r + 2'd1;
    end
  end

  assign prog   = prog_r;
  assign modulo = modulo_r;
  assign data_2 = data_r;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: two instances (TICK_DIV 4 and 1) share stimulus and are
// compared every cycle against an index-based model of each sequence.
module tb_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, btn_prog, btn_mod, hold;
  logic [2:0]  prog4, prog1;
  logic [1:0]  mod4, mod1;
  logic [15:0] data4, data1;

  seq_gen #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .btn_prog(btn_prog), .btn_mod(btn_mod), .hold(hold),
    .prog(prog4), .modulo(mod4), .data_2(data4)
  );
  seq_gen #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .btn_prog(btn_prog), .btn_mod(btn_mod), .hold(hold),
    .prog(prog1), .modulo(mod1), .data_2(data1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_div [2] = '{4, 1};
  int m_prog[2], m_mod[2], m_k[2], m_pre[2], m_cnt[2];
  logic [2:0] hp, hm;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fib_at(input int i);
    int a = 0, b = 1, t;
    for (int j = 0; j < i; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Value of sequence p after k steps from its start value
  function automatic int seq_value(input int p, input int k);
    int m;
    case (p)
      0: return k % 10000;
      1: return 9999 - (k % 10000);
      2: return fib_at(k % 21);
      3: return 2 * (k % 5000);
      4: return 1 + 2 * (k % 5000);
      5: begin m = k % 100; return m * m; end
      6: return 1 << (k % 14);
      7: begin m = k % 141; return m * (m + 1) / 2; end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_prog[i] = 0; m_mod[i] = 0; m_k[i] = 0; m_pre[i] = 0; m_cnt[i] = 0;
    end
    hp = 3'd0;
    hm = 3'd0;
  endtask

  task automatic model_edge(input logic h, input logic bp, input logic bm);
    logic pp, pm, tk, st;
    pp = hp[1] & ~hp[2];
    pm = hm[1] & ~hm[2];
    for (int i = 0; i < 2; i++) begin
      tk = !h && (m_pre[i] == m_div[i] - 1);
      st = tk && (m_cnt[i] == (1 << m_mod[i]) - 1);
      if (pp) begin
        m_prog[i] = (m_prog[i] + 1) % 8;
        m_k[i] = 0; m_pre[i] = 0; m_cnt[i] = 0;
      end else begin
        if (!h) m_pre[i] = tk ? 0 : m_pre[i] + 1;
        if (tk) m_cnt[i] = st ? 0 : m_cnt[i] + 1;
        if (st) m_k[i]++;
      end
      if (pm) begin
        m_mod[i] = (m_mod[i] + 1) % 4;
        m_cnt[i] = 0;
      end
    end
    hp = {hp[1:0], bp};
    hm = {hm[1:0], bm};
  endtask

  task automatic compare_all();
    check_val("prog_div4",   prog4, m_prog[0]);
    check_val("modulo_div4", mod4,  m_mod[0]);
    check_val("data_div4",   data4, seq_value(m_prog[0], m_k[0]));
    check_val("prog_div1",   prog1, m_prog[1]);
    check_val("modulo_div1", mod1,  m_mod[1]);
    check_val("data_div1",   data1, seq_value(m_prog[1], m_k[1]));
  endtask

  task automatic cycle();
    logic h, bp, bm, r;
    h = hold; bp = btn_prog; bm = btn_mod; r = rst;
    @(posedge clk);
    if (r) model_edge(h, bp, bm);
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    run(2);
    rst = 1'b1;
  endtask

  task automatic press_prog();
    btn_prog = 1'b1;
    run(3);
    btn_prog = 1'b0;
    run(1);
  endtask

  initial begin
    rst = 1'b0; btn_prog = 1'b0; btn_mod = 1'b0; hold = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    check_val("reset_data4", data4, 32'd0);

    run(4);  check_val("d4_first",  data4, 32'd1);
    check_val("d1_fourth", data1, 32'd4);
    run(4);  check_val("d4_second", data4, 32'd2);
    run(4);  check_val("d4_third",  data4, 32'd3);

    do_reset();
    run(9999); check_val("up_top",  data1, 32'd9999);
    run(1);    check_val("up_wrap", data1, 32'd0);

    btn_prog = 1'b1;
    run(3);    check_val("down_prog",  prog1, 32'd1);
    check_val("down_start", data1, 32'd9999);
    run(1);    check_val("down_step",  data1, 32'd9998);
    btn_prog = 1'b0;
    run(3);

    btn_prog = 1'b1;
    run(3);    check_val("fib_start", data1, 32'd0);
    btn_prog = 1'b0;
    run(20);   check_val("fib_top",  data1, 32'd6765);
    run(1);    check_val("fib_wrap", data1, 32'd0);
    run(1);    check_val("fib_one",  data1, 32'd1);

    btn_mod = 1'b1;
    run(3);    check_val("mod_once", mod4, 32'd1);
    btn_mod = 1'b0;
    run(40);

    press_prog(); press_prog(); press_prog();
    btn_prog = 1'b1;
    run(3);    check_val("pow2_prog",  prog1, 32'd6);
    check_val("pow2_start", data1, 32'd1);
    btn_prog = 1'b0;
    run(60);

    hold = 1'b1;
    run(20);
    hold = 1'b0;
    run(10);
    do_reset();
    check_val("midrun_prog", prog4, 32'd0);
    check_val("midrun_data", data1, 32'd0);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 11))
        0, 1: begin
          btn_prog = 1'b1; run($urandom_range(1, 5));
          btn_prog = 1'b0; run($urandom_range(1, 5));
        end
        2, 3: begin
          btn_mod = 1'b1; run($urandom_range(1, 5));
          btn_mod = 1'b0; run($urandom_range(1, 5));
        end
        4: begin
          hold = ~hold; run($urandom_range(1, 20));
        end
        5: if ($urandom_range(0, 3) == 0) do_reset();
           else run(3);
        default: run($urandom_range(1, 40));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
